// File: rtl/vred_sequencer_pkg.sv
// Shared types and helpers for the vector-reduction sequencer: FSM states,
// op-select / element-width encodings and the per-op identity element.
package vred_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_SUM, OP_MAX, OP_MIN, OP_AND, OP_OR, OP_XOR
  } op_t;

  // arithmetic ops decode opSel[2:1], logic ops decode opSel[1:0]
  localparam logic [1:0] ARITH_SUM = 2'b00;
  localparam logic [1:0] ARITH_MAX = 2'b01;
  localparam logic [1:0] ARITH_MIN = 2'b10;
  localparam logic [1:0] LOGIC_AND = 2'b01;
  localparam logic [1:0] LOGIC_OR  = 2'b10;
  localparam logic [1:0] LOGIC_XOR = 2'b11;

  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;
  localparam logic [1:0] SEW_32 = 2'b10;
  localparam logic [1:0] SEW_64 = 2'b11;

  function automatic op_t decode_op(input logic lop, input logic [2:0] opsel);
    op_t op;
    op = OP_SUM;
    if (lop) begin
      case (opsel[1:0])
        LOGIC_AND: op = OP_AND;
        LOGIC_XOR: op = OP_XOR;
        default:   op = OP_OR;
      endcase
    end else begin
      case (opsel[2:1])
        ARITH_MAX: op = OP_MAX;
        ARITH_MIN: op = OP_MIN;
        default:   op = OP_SUM;
      endcase
    end
    return op;
  endfunction

  // identity element, right-aligned in the element width selected by sew
  function automatic logic [63:0] identity(input op_t op, input logic [1:0] sew);
    logic [63:0] mask;
    logic [63:0] id;
    case (sew)
      SEW_8:   mask = 64'h0000_0000_0000_00FF;
      SEW_16:  mask = 64'h0000_0000_0000_FFFF;
      SEW_32:  mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    case (op)
      OP_AND:  id = mask;
      OP_MAX:  id = mask ^ (mask >> 1);
      OP_MIN:  id = mask >> 1;
      default: id = '0;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/vred_tail_fill.sv
// Replaces every element lane at index >= valid count with the op identity.
// Purely combinational; works byte-by-byte so any element width maps cleanly.
module vred_tail_fill
  import vred_sequencer_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 8
) (
  input  logic [DATA_W-1:0] i_beat,
  input  logic [1:0]        i_sew,
  input  op_t               i_op,
  input  logic [CNT_W-1:0]  i_valid_cnt,
  output logic [DATA_W-1:0] o_beat
);
  localparam int NB = DATA_W / 8;

  logic [63:0] w_ident;
  assign w_ident = identity(i_op, i_sew);

  for (genvar b = 0; b < NB; b++) begin : g_byte
    logic [CNT_W-1:0] w_idx;
    logic [2:0]       w_off;
    // element this byte belongs to, and its byte position inside that element
    assign w_idx = CNT_W'(b) >> i_sew;
    assign w_off = 3'(b) & ((3'd1 << i_sew) - 3'd1);
    assign o_beat[8*b +: 8] = (w_idx >= i_valid_cnt) ? w_ident[8*w_off +: 8]
                                                     : i_beat[8*b +: 8];
  end

endmodule

// File: rtl/vred_sequencer.sv
// Vector reduction sequencer: takes one reduction command, streams vs2 beats
// to the reduction unit with tail/bubble identity fill, then writes back.
module vred_sequencer
  import vred_sequencer_pkg::*;
#(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH = 32,
  parameter int OPSEL_WIDTH    = 3,
  parameter int SEW_WIDTH      = 2,
  parameter int VL_WIDTH       = 8,
  parameter int ENABLE_64_BIT  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_lop_sum,
  input  logic [OPSEL_WIDTH-1:0]      cmd_opSel,
  input  logic [SEW_WIDTH-1:0]        cmd_sew,
  input  logic [VL_WIDTH-1:0]         cmd_vl,
  input  logic [REQ_DATA_WIDTH-1:0]   cmd_scalar,
  input  logic [REQ_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                        src_valid,
  output logic                        src_ready,
  input  logic [REQ_DATA_WIDTH-1:0]   src_data,
  output logic                        red_valid,
  output logic                        red_start,
  output logic                        red_end,
  output logic                        red_lop_sum,
  output logic [OPSEL_WIDTH-1:0]      red_opSel,
  output logic [SEW_WIDTH-1:0]        red_sew,
  output logic [REQ_DATA_WIDTH-1:0]   red_vec0,
  output logic [REQ_DATA_WIDTH-1:0]   red_vec1,
  output logic [REQ_ADDR_WIDTH-1:0]   red_addr,
  input  logic                        red_out_valid,
  input  logic [REQ_DATA_WIDTH-1:0]   red_out_vec,
  input  logic [REQ_DATA_WIDTH/8-1:0] red_out_be,
  input  logic [REQ_ADDR_WIDTH-1:0]   red_out_addr,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [REQ_DATA_WIDTH-1:0]   wb_data,
  output logic [REQ_DATA_WIDTH/8-1:0] wb_be,
  output logic [REQ_ADDR_WIDTH-1:0]   wb_addr,
  output logic                        busy,
  output logic                        err
);
  localparam int LOG_BB = (ENABLE_64_BIT != 0) ? 3 : 2;
  localparam int BE_W   = REQ_DATA_WIDTH / 8;

  state_t                      r_state;
  logic                        r_live;
  logic                        r_lop;
  logic [OPSEL_WIDTH-1:0]      r_opsel;
  logic [SEW_WIDTH-1:0]        r_sew;
  logic [REQ_DATA_WIDTH-1:0]   r_scalar;
  logic [REQ_ADDR_WIDTH-1:0]   r_addr;
  logic [VL_WIDTH-1:0]         r_beats_left, r_last_cnt, r_epb;
  logic                        r_first;
  logic                        r_red_valid, r_red_start, r_red_end;
  logic [REQ_DATA_WIDTH-1:0]   r_red_vec0, r_red_vec1;
  logic [REQ_DATA_WIDTH-1:0]   r_wb_data;
  logic [BE_W-1:0]             r_wb_be;
  logic [REQ_ADDR_WIDTH-1:0]   r_wb_addr;
  logic                        r_err;

  // beat geometry from the incoming command; epb is a power of two
  logic [1:0]          w_sew2;
  logic [2:0]          w_lg;
  logic [VL_WIDTH-1:0] w_epb, w_beats, w_last;
  logic [VL_WIDTH:0]   w_sum;
  logic                w_sew_bad, w_cmd_fire;

  assign w_sew2     = 2'(cmd_sew);
  assign w_lg       = 3'(LOG_BB) - {1'b0, w_sew2};
  assign w_epb      = VL_WIDTH'(1) << w_lg;
  assign w_sum      = {1'b0, cmd_vl} + {1'b0, w_epb} - (VL_WIDTH+1)'(1);
  assign w_beats    = VL_WIDTH'(w_sum >> w_lg);
  assign w_last     = cmd_vl - VL_WIDTH'((w_beats - VL_WIDTH'(1)) << w_lg);
  assign w_sew_bad  = (w_sew2 == SEW_64) && (ENABLE_64_BIT == 0);
  assign w_cmd_fire = cmd_valid && cmd_ready;

  logic                      w_is_last;
  logic [VL_WIDTH-1:0]       w_fill_cnt;
  logic [REQ_DATA_WIDTH-1:0] w_filled;
  op_t                       w_op;

  assign w_is_last  = (r_beats_left == VL_WIDTH'(1));
  // a bubble fills every lane with identity
  assign w_fill_cnt = !src_valid ? '0 : (w_is_last ? r_last_cnt : r_epb);
  assign w_op       = decode_op(r_lop, 3'(r_opsel));

  vred_tail_fill #(
    .DATA_W (REQ_DATA_WIDTH),
    .CNT_W  (VL_WIDTH)
  ) u_fill (
    .i_beat      (src_data),
    .i_sew       (2'(r_sew)),
    .i_op        (w_op),
    .i_valid_cnt (w_fill_cnt),
    .o_beat      (w_filled)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_live       <= 1'b0;
      r_lop        <= 1'b0;
      r_opsel      <= '0;
      r_sew        <= '0;
      r_scalar     <= '0;
      r_addr       <= '0;
      r_beats_left <= '0;
      r_last_cnt   <= '0;
      r_epb        <= '0;
      r_first      <= 1'b0;
      r_red_valid  <= 1'b0;
      r_red_start  <= 1'b0;
      r_red_end    <= 1'b0;
      r_red_vec0   <= '0;
      r_red_vec1   <= '0;
      r_wb_data    <= '0;
      r_wb_be      <= '0;
      r_wb_addr    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      r_err       <= 1'b0;
      r_red_valid <= 1'b0;
      r_red_start <= 1'b0;
      r_red_end   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            r_lop        <= cmd_lop_sum;
            r_opsel      <= cmd_opSel;
            r_sew        <= cmd_sew;
            r_scalar     <= cmd_scalar;
            r_addr       <= cmd_addr;
            r_beats_left <= w_beats;
            r_last_cnt   <= w_last;
            r_epb        <= w_epb;
            if (w_sew_bad) begin
              r_err <= 1'b1;
            end else if (cmd_vl != '0) begin
              r_first <= 1'b1;
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (src_valid || !r_first) begin
            r_red_valid <= 1'b1;
            r_red_vec0  <= w_filled;
            r_red_start <= src_valid && r_first;
            r_red_end   <= src_valid && w_is_last;
            r_red_vec1  <= (src_valid && r_first) ? r_scalar : '0;
            if (src_valid) begin
              r_first      <= 1'b0;
              r_beats_left <= r_beats_left - VL_WIDTH'(1);
              if (w_is_last) r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (red_out_valid) begin
            r_wb_data <= red_out_vec;
            r_wb_be   <= red_out_be;
            r_wb_addr <= red_out_addr;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (wb_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_live && (r_state == ST_IDLE);
  assign src_ready   = (r_state == ST_ISSUE);
  assign red_valid   = r_red_valid;
  assign red_start   = r_red_start;
  assign red_end     = r_red_end;
  assign red_lop_sum = r_lop;
  assign red_opSel   = r_opsel;
  assign red_sew     = r_sew;
  assign red_vec0    = r_red_vec0;
  assign red_vec1    = r_red_vec1;
  assign red_addr    = r_addr;
  assign wb_valid    = (r_state == ST_RESP);
  assign wb_data     = r_wb_data;
  assign wb_be       = r_wb_be;
  assign wb_addr     = r_wb_addr;
  assign busy        = (r_state != ST_IDLE);
  assign err         = r_err;

endmodule

// File: tb/tb_vred_sequencer.sv
// Scoreboard bench for vred_sequencer: directed commands push expected
// reduction beats and writebacks; a monitor pops and compares on valid.
module tb_vred_sequencer;
  localparam int DW = 64, AW = 32, OW = 3, SW = 2, VW = 8;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 0, cmd_ready, cmd_lop_sum = 0;
  logic [OW-1:0] cmd_opSel = 0;
  logic [SW-1:0] cmd_sew = 0;
  logic [VW-1:0] cmd_vl = 0;
  logic [DW-1:0] cmd_scalar = 0;
  logic [AW-1:0] cmd_addr = 0;
  logic          src_valid = 0, src_ready;
  logic [DW-1:0] src_data = 0;
  logic          red_valid, red_start, red_end, red_lop_sum;
  logic [OW-1:0] red_opSel;
  logic [SW-1:0] red_sew;
  logic [DW-1:0] red_vec0, red_vec1;
  logic [AW-1:0] red_addr;
  logic          red_out_valid = 0;
  logic [DW-1:0] red_out_vec = 0;
  logic [7:0]    red_out_be = 0;
  logic [AW-1:0] red_out_addr = 0;
  logic          wb_valid, wb_ready = 1;
  logic [DW-1:0] wb_data;
  logic [7:0]    wb_be;
  logic [AW-1:0] wb_addr;
  logic          busy, err;

  vred_sequencer #(.REQ_DATA_WIDTH(DW), .REQ_ADDR_WIDTH(AW), .OPSEL_WIDTH(OW),
                   .SEW_WIDTH(SW), .VL_WIDTH(VW), .ENABLE_64_BIT(0)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_lop_sum(cmd_lop_sum),
    .cmd_opSel(cmd_opSel), .cmd_sew(cmd_sew), .cmd_vl(cmd_vl),
    .cmd_scalar(cmd_scalar), .cmd_addr(cmd_addr),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .red_valid(red_valid), .red_start(red_start), .red_end(red_end),
    .red_lop_sum(red_lop_sum), .red_opSel(red_opSel), .red_sew(red_sew),
    .red_vec0(red_vec0), .red_vec1(red_vec1), .red_addr(red_addr),
    .red_out_valid(red_out_valid), .red_out_vec(red_out_vec),
    .red_out_be(red_out_be), .red_out_addr(red_out_addr),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_be(wb_be), .wb_addr(wb_addr), .busy(busy), .err(err)
  );

  typedef struct {
    logic st; logic en; logic [63:0] v0; logic [63:0] v1;
    logic lop; logic [2:0] op; logic [1:0] sew; logic [31:0] addr;
  } red_exp_t;
  typedef struct { logic [63:0] d; logic [7:0] be; logic [31:0] a; } wb_exp_t;

  red_exp_t rq[$];
  wb_exp_t  wq[$];
  int n_cmp = 0, n_bad = 0;

  logic        c_lop;
  logic [2:0]  c_op;
  logic [1:0]  c_sew;
  logic [63:0] c_scalar;
  logic [31:0] c_addr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_red(input logic st, input logic en, input logic [63:0] v0);
    red_exp_t e;
    e.st = st; e.en = en; e.v0 = v0; e.v1 = c_scalar;
    e.lop = c_lop; e.op = c_op; e.sew = c_sew; e.addr = c_addr;
    rq.push_back(e);
  endtask

  task automatic push_wb(input logic [63:0] d, input logic [7:0] be, input logic [31:0] a);
    wb_exp_t e;
    e.d = d; e.be = be; e.a = a;
    wq.push_back(e);
  endtask

  // monitor: pops on every presented beat / writeback handshake
  always @(negedge clk) begin : mon
    red_exp_t e;
    if (rst) begin
      if (red_valid) begin
        if (rq.size() == 0) chk("unexpected red_valid", 1, 0);
        else begin
          e = rq.pop_front();
          chk("red_start", red_start, e.st);
          chk("red_end", red_end, e.en);
          chk("red_vec0", red_vec0, e.v0);
          if (e.st) chk("red_vec1", red_vec1, e.v1);
          chk("red_lop_sum", red_lop_sum, e.lop);
          chk("red_opSel", red_opSel, e.op);
          chk("red_sew", red_sew, e.sew);
          chk("red_addr", red_addr, e.addr);
        end
      end
      if (wb_valid) begin
        if (wq.size() == 0) chk("unexpected wb_valid", 1, 0);
        else begin
          chk("wb_data", wb_data, wq[0].d);
          chk("wb_be", wb_be, wq[0].be);
          chk("wb_addr", wb_addr, wq[0].a);
          if (wb_ready) void'(wq.pop_front());
        end
      end
    end
  end

  // reduction unit stand-in: folds every beat, answers 5 cycles after red_end
  function automatic logic [63:0] emask(input logic [1:0] s);
    case (s)
      2'd0: return 64'hFF;
      2'd1: return 64'hFFFF;
      2'd2: return 64'hFFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic signed [63:0] sx(input logic [63:0] v, input logic [1:0] s);
    int sh;
    sh = 64 - (8 << s);
    return $signed(v << sh) >>> sh;
  endfunction

  function automatic logic [63:0] comb(input logic lop, input logic [2:0] op,
                                       input logic [1:0] s, input logic [63:0] a,
                                       input logic [63:0] b);
    logic [63:0] r;
    r = a;
    if (lop) begin
      case (op[1:0])
        2'b01: r = a & b;
        2'b10: r = a | b;
        2'b11: r = a ^ b;
        default: r = a;
      endcase
    end else begin
      case (op[2:1])
        2'b00: r = a + b;
        2'b01: r = (sx(a, s) > sx(b, s)) ? a : b;
        2'b10: r = (sx(a, s) < sx(b, s)) ? a : b;
        default: r = a;
      endcase
    end
    return r & emask(s);
  endfunction

  logic [63:0] s_acc = 0;
  logic [7:0]  s_be = 0;
  logic [31:0] s_addr = 0;
  int          s_cnt = -1;
  always @(negedge clk) begin
    red_out_valid = 1'b0;
    if (s_cnt == 0) begin
      red_out_valid = 1'b1;
      red_out_vec   = s_acc;
      red_out_be    = s_be;
      red_out_addr  = s_addr;
    end
    if (s_cnt >= 0) s_cnt--;
    if (red_valid) begin
      if (red_start) s_acc = red_vec1 & emask(red_sew);
      for (int i = 0; i < (8 >> red_sew); i++)
        s_acc = comb(red_lop_sum, red_opSel, red_sew, s_acc,
                     (red_vec0 >> (i * (8 << red_sew))) & emask(red_sew));
      if (red_end) begin
        s_cnt  = 4;
        s_be   = 8'((16'd1 << (1 << red_sew)) - 16'd1);
        s_addr = red_addr;
      end
    end
  end

  task automatic cmd(input logic lop, input logic [2:0] op, input logic [1:0] sew,
                     input logic [7:0] vl, input logic [63:0] sc, input logic [31:0] ad);
    int n;
    c_lop = lop; c_op = op; c_sew = sew; c_scalar = sc; c_addr = ad;
    cmd_valid = 1; cmd_lop_sum = lop; cmd_opSel = op; cmd_sew = sew;
    cmd_vl = vl; cmd_scalar = sc; cmd_addr = ad;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd_ready timeout", 0, 1);
    @(posedge clk); #1 cmd_valid = 0;
  endtask

  task automatic beat(input logic [63:0] d);
    int n;
    src_valid = 1; src_data = d;
    n = 0;
    @(negedge clk);
    while (!src_ready && n < 50) begin @(negedge clk); n++; end
    if (!src_ready) chk("src_ready timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic bubble(input int n);
    src_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    src_valid = 0;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) chk("idle timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin : main
    int n;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cmd_ready", cmd_ready, 0);
    chk("rst src_ready", src_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst red_valid", red_valid, 0);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_data", wb_data, 0);
    chk("rst err", err, 0);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("cmd_ready before first clock", cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready after release", cmd_ready, 1);
    @(posedge clk); #1;

    // sum, sew8, vl=10 over 4-byte beats; upper lanes must be identity
    cmd(0, 3'b000, 2'd0, 8'd10, 64'd5, 32'h100);
    push_red(1, 0, 64'h0000_0000_0403_0201);
    push_red(0, 0, 64'h0000_0000_0807_0605);
    push_red(0, 1, 64'h0000_0000_0000_0A09);
    push_wb(64'h3C, 8'h01, 32'h100);
    beat(64'hDEAD_BEEF_0403_0201);
    beat(64'hDEAD_BEEF_0807_0605);
    beat(64'h0000_0000_EEEE_0A09);
    wait_idle();

    // xor, sew32, vl=3 with two bubbles after the first beat
    cmd(1, 3'b011, 2'd2, 8'd3, 64'h1111_1111, 32'h200);
    push_red(1, 0, 64'h0000_00FF);
    push_red(0, 0, 64'h0);
    push_red(0, 0, 64'h0);
    push_red(0, 0, 64'h0000_FF00);
    push_red(0, 1, 64'h1234_5678);
    push_wb(64'h0325_B896, 8'h0F, 32'h200);
    beat(64'hAAAA_AAAA_0000_00FF);
    bubble(2);
    beat(64'h0000_FF00);
    beat(64'hFFFF_FFFF_1234_5678);
    wait_idle();

    // and, sew16, vl=1: single start+end beat
    cmd(1, 3'b001, 2'd1, 8'd1, 64'hFFFF_F0F0, 32'h300);
    push_red(1, 1, 64'hFFFF_FFFF_FFFF_1234);
    push_wb(64'h1030, 8'h03, 32'h300);
    beat(64'h0000_0000_5555_1234);
    wait_idle();

    // vl=0 is dropped silently
    cmd(0, 3'b000, 2'd0, 8'd0, 64'd0, 32'h400);
    @(negedge clk);
    chk("vl0 cmd_ready", cmd_ready, 1);
    chk("vl0 busy", busy, 0);
    @(posedge clk); #1;
    // sew=11 without 64-bit beats pulses err
    cmd(0, 3'b000, 2'd3, 8'd4, 64'd0, 32'h410);
    @(negedge clk);
    chk("sew64 err pulse", err, 1);
    chk("sew64 busy", busy, 0);
    @(negedge clk);
    chk("sew64 err clears", err, 0);
    repeat (3) @(posedge clk);
    #1;

    // max, sew8, vl=5, negative values; writeback stalled 3 cycles
    wb_ready = 0;
    cmd(0, 3'b010, 2'd0, 8'd5, 64'h9C, 32'h500);
    push_red(1, 0, 64'h8080_8080_F7FF_F9FD);
    push_red(0, 1, 64'h8080_8080_8080_80FE);
    push_wb(64'hFF, 8'h01, 32'h500);
    beat(64'h0000_0000_F7FF_F9FD);
    beat(64'h0000_0000_1234_56FE);
    src_valid = 0;
    n = 0;
    @(negedge clk);
    while (!wb_valid && n < 100) begin @(negedge clk); n++; end
    if (!wb_valid) chk("wb_valid timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1 wb_ready = 1;
    wait_idle();

    // reset while waiting for the result; the late result must be ignored
    cmd(0, 3'b000, 2'd2, 8'd1, 64'd0, 32'h600);
    push_red(1, 1, 64'h42);
    beat(64'h42);
    src_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("mid-wait rst busy", busy, 0);
    chk("mid-wait rst cmd_ready", cmd_ready, 0);
    chk("mid-wait rst red_valid", red_valid, 0);
    @(posedge clk); #1 rst = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("late result wb_valid", wb_valid, 0);
    end
    chk("late result busy", busy, 0);

    chk("red queue drained", 64'(rq.size()), 0);
    chk("wb queue drained", 64'(wq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
